// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and imem.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  // Fetch stage side: drives the address, consumes data and ready.
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  // Memory side.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register. Holds the PC, fetches from imem, executes
// PC_Src redirects and inserts bubbles for imem wait states and stalls.
// Optional feature macro: FETCH_DELAY_SLOT_EN (MIPS branch delay slot, no squash).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  PC_Src,
  input  logic [31:0] jr_target,
  fetch_unit_if.master bus,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        inst_valid,
  output logic        flush
);

  typedef enum logic [0:0] {StRun, StSlotWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic        redirect;

  // jr targets are word aligned; the low two bits of rs are dropped.
  logic unused_jr_low;
  assign unused_jr_low = ^jr_target[1:0];

  // Redirect target selection from the instruction currently in IF/ID.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    redirect = (PC_Src != 2'b00);
    unique case (PC_Src)
      2'b01:   target = pc4_q + br_off;
      2'b10:   target = {jr_target[31:2], 2'b00};
      2'b11:   target = {pc4_q[31:28], inst_q[25:0], 2'b00};
      default: target = pc_plus4;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; SLOT_WAIT is only reachable with the delay slot enabled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
`ifdef FETCH_DELAY_SLOT_EN
        if (!stall && redirect && !bus.imem_ready) state_d = StSlotWait;
`else
        state_d = StRun;
`endif
      end
      StSlotWait: begin
        if (!stall && bus.imem_ready) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Datapath next values: priority stall > redirect > imem wait > sequential.
  always_comb begin
    pc_d          = pc_q;
    inst_d        = inst_q;
    pc4_d         = pc4_q;
    valid_d       = valid_q;
    flush_d       = 1'b0;
    pend_target_d = pend_target_q;
    if (!stall) begin
`ifdef FETCH_DELAY_SLOT_EN
      unique case (state_q)
        StRun: begin
          if (redirect && bus.imem_ready) begin
            // Delay-slot word is kept, PC jumps straight to the target.
            pc_d    = target;
            inst_d  = bus.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end else if (redirect) begin
            // Slot not yet fetched: remember the target until it arrives.
            pend_target_d = target;
            inst_d        = NOP_INST;
            valid_d       = 1'b0;
          end else if (!bus.imem_ready) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end else begin
            pc_d    = pc_plus4;
            inst_d  = bus.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end
        StSlotWait: begin
          if (bus.imem_ready) begin
            pc_d    = pend_target_q;
            inst_d  = bus.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end else begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase
`else
      if (redirect) begin
        // Wrong-path word is discarded and the slot is marked squashed.
        pc_d    = target;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
        flush_d = 1'b1;
      end else if (!bus.imem_ready) begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        inst_d  = bus.imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
`endif
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inst_q        <= NOP_INST;
      pc4_q         <= 32'h0000_0000;
      valid_q       <= 1'b0;
      flush_q       <= 1'b0;
      pend_target_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      pc4_q         <= pc4_d;
      valid_q       <= valid_d;
      flush_q       <= flush_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Outputs: imem address follows the PC; flush never asserts in delay-slot mode.
  always_comb begin
    bus.imem_addr = pc_q;
    inst          = inst_q;
    pc4           = pc4_q;
    inst_valid    = valid_q;
`ifdef FETCH_DELAY_SLOT_EN
    flush         = 1'b0;
`else
    flush         = flush_q;
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of per-cycle vectors plus hand sequences.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] jr_target;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic        inst_valid;
  logic        flush;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .PC_Src    (pc_src),
    .jr_target (jr_target),
    .bus       (bus),
    .inst      (inst),
    .pc4       (pc4),
    .inst_valid(inst_valid),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  src;
    logic [31:0] jr;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_flush;
  } vec_t;

  vec_t vecs[22];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [31:0] ea, input logic [31:0] ei,
                           input logic [31:0] ep, input logic ev, input logic ef);
    chk({nm, ".addr"}, bus.imem_addr, ea);
    chk({nm, ".inst"}, inst, ei);
    chk({nm, ".pc4"}, pc4, ep);
    chk({nm, ".valid"}, {31'd0, inst_valid}, {31'd0, ev});
    chk({nm, ".flush"}, {31'd0, flush}, {31'd0, ef});
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic cyc(input string nm, input logic st, input logic [1:0] src,
                     input logic [31:0] jr, input logic rdy, input logic [31:0] rd,
                     input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                     input logic ev, input logic ef);
    stall          = st;
    pc_src         = src;
    jr_target      = jr;
    bus.imem_ready = rdy;
    bus.imem_rdata = rd;
    @(posedge clk);
    #1;
    check_all(nm, ea, ei, ep, ev, ef);
  endtask

  initial begin
    // stall src jr ready rdata | addr inst pc4 valid flush
    vecs[0]  = '{0, 2'b00, 0, 1, 32'hAAAA_0001, 32'h4, 32'hAAAA_0001, 32'h4, 1, 0};
    vecs[1]  = '{0, 2'b00, 0, 1, 32'hBBBB_0002, 32'h8, 32'hBBBB_0002, 32'h8, 1, 0};
    vecs[2]  = '{0, 2'b00, 0, 1, 32'hCCCC_0003, 32'hC, 32'hCCCC_0003, 32'hC, 1, 0};
    vecs[3]  = '{0, 2'b00, 0, 1, 32'hDDDD_0004, 32'h10, 32'hDDDD_0004, 32'h10, 1, 0};
    // beq with imm 3 fetched at 0x10
    vecs[4]  = '{0, 2'b00, 0, 1, 32'h1000_0003, 32'h14, 32'h1000_0003, 32'h14, 1, 0};
    // branch taken: 0x14 + 12 = 0x20, wrong-path word dropped
    vecs[5]  = '{0, 2'b01, 0, 1, 32'hDEAD_BEEF, 32'h20, NOP, 32'h14, 0, 1};
    vecs[6]  = '{0, 2'b00, 0, 1, 32'hEEEE_0005, 32'h24, 32'hEEEE_0005, 32'h24, 1, 0};
    // two imem wait cycles
    vecs[7]  = '{0, 2'b00, 0, 0, 32'h1111_1111, 32'h24, NOP, 32'h24, 0, 0};
    vecs[8]  = '{0, 2'b00, 0, 0, 32'h2222_2222, 32'h24, NOP, 32'h24, 0, 0};
    vecs[9]  = '{0, 2'b00, 0, 1, 32'hFFFF_0006, 32'h28, 32'hFFFF_0006, 32'h28, 1, 0};
    // jr, low bits dropped
    vecs[10] = '{0, 2'b10, 32'h0000_4003, 1, 32'h3333_3333, 32'h4000, NOP, 32'h28, 0, 1};
    vecs[11] = '{0, 2'b00, 0, 1, 32'h1234_5678, 32'h4004, 32'h1234_5678, 32'h4004, 1, 0};
    vecs[12] = '{0, 2'b10, 32'h4000_000F, 1, 32'h4444_4444, 32'h4000_000C, NOP, 32'h4004, 0, 1};
    // j with inst[25:0]=0x10 at pc 0x4000_000C
    vecs[13] = '{0, 2'b00, 0, 1, 32'h0800_0010, 32'h4000_0010, 32'h0800_0010, 32'h4000_0010, 1, 0};
    vecs[14] = '{0, 2'b11, 0, 1, 32'h5555_5555, 32'h4000_0040, NOP, 32'h4000_0010, 0, 1};
    // beq imm -1, then stall while PC_Src requests the branch
    vecs[15] = '{0, 2'b00, 0, 1, 32'h1000_FFFF, 32'h4000_0044, 32'h1000_FFFF, 32'h4000_0044, 1, 0};
    vecs[16] = '{1, 2'b01, 0, 1, 32'h6666_6666, 32'h4000_0044, 32'h1000_FFFF, 32'h4000_0044, 1, 0};
    vecs[17] = '{1, 2'b01, 0, 0, 32'h7777_7777, 32'h4000_0044, 32'h1000_FFFF, 32'h4000_0044, 1, 0};
    vecs[18] = '{0, 2'b01, 0, 1, 32'h8888_8888, 32'h4000_0040, NOP, 32'h4000_0044, 0, 1};
    vecs[19] = '{0, 2'b00, 0, 1, 32'h9999_0007, 32'h4000_0044, 32'h9999_0007, 32'h4000_0044, 1, 0};
    // pc wraps FFFF_FFFC -> 0
    vecs[20] = '{0, 2'b10, 32'hFFFF_FFFF, 1, 32'hAAAA_AAAA, 32'hFFFF_FFFC, NOP, 32'h4000_0044, 0, 1};
    vecs[21] = '{0, 2'b00, 0, 1, 32'hABCD_0008, 32'h0, 32'hABCD_0008, 32'h0, 1, 0};

    reset          = 1'b1;
    stall          = 1'b0;
    pc_src         = 2'b00;
    jr_target      = '0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hFACE_FACE;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

`ifndef FETCH_DELAY_SLOT_EN
    for (int i = 0; i < 22; i++) begin
      cyc($sformatf("v%0d", i), vecs[i].stall, vecs[i].src, vecs[i].jr, vecs[i].ready,
          vecs[i].rdata, vecs[i].e_addr, vecs[i].e_inst, vecs[i].e_pc4, vecs[i].e_valid,
          vecs[i].e_flush);
    end
    // reset wins over a concurrent redirect
    reset = 1'b1;
    cyc("rst_mid", 0, 2'b10, 32'h0000_8000, 1, 32'h1, 32'h0, NOP, 32'h0, 0, 0);
    reset = 1'b0;
    cyc("post_rst", 0, 2'b00, 0, 1, 32'hC0DE_0001, 32'h4, 32'hC0DE_0001, 32'h4, 1, 0);
`else
    cyc("ds_a", 0, 2'b00, 0, 1, 32'hAAAA_0001, 32'h4, 32'hAAAA_0001, 32'h4, 1, 0);
    // j to 0x100 fetched at 4
    cyc("ds_j", 0, 2'b00, 0, 1, 32'h0800_0040, 32'h8, 32'h0800_0040, 32'h8, 1, 0);
    cyc("ds_wait0", 0, 2'b11, 0, 0, 32'h1, 32'h8, NOP, 32'h8, 0, 0);
    cyc("ds_wait1", 0, 2'b11, 0, 0, 32'h2, 32'h8, NOP, 32'h8, 0, 0);
    cyc("ds_hold", 1, 2'b00, 0, 1, 32'h3, 32'h8, NOP, 32'h8, 0, 0);
    cyc("ds_slot", 0, 2'b00, 0, 1, 32'h5151_0001, 32'h100, 32'h5151_0001, 32'hC, 1, 0);
    cyc("ds_tgt", 0, 2'b00, 0, 1, 32'h7777_0002, 32'h104, 32'h7777_0002, 32'h104, 1, 0);
    cyc("ds_rdy", 0, 2'b10, 32'h200, 1, 32'h9999_0003, 32'h200, 32'h9999_0003, 32'h108, 1, 0);
    cyc("ds_w2", 0, 2'b10, 32'h300, 0, 32'h4, 32'h200, NOP, 32'h108, 0, 0);
    reset = 1'b1;
    cyc("ds_rst", 0, 2'b00, 0, 0, 32'h5, 32'h0, NOP, 32'h0, 0, 0);
    reset = 1'b0;
    // back in RUN: sequential, not a jump to a stale pending target
    cyc("ds_run", 0, 2'b00, 0, 1, 32'hBEEF_0004, 32'h4, 32'hBEEF_0004, 32'h4, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
